// File: rtl/core_pkg.sv
// Shared RV32 core definitions: fetch FSM encoding, instruction size and the
// major opcodes the decoder also keys on.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SQUASH = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } fetch_state_t;

  localparam int unsigned INSN_BYTES = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one outstanding memory read, a single-entry
// instruction buffer toward the decoder, and redirect / misaligned-target handling.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            nRst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            dec_ready,
  output logic            inst_valid,
  output logic [6:0]      opcode,
  output logic [24:0]     instruction,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] squash_tgt;
  fetch_state_t    redir_st;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      buf_q      <= '0;
      inst_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    inst_pc_d  = inst_pc_q;
    redir_st   = misaligned(redirect_pc) ? FAULT : FETCH;
    squash_tgt = redirect ? redirect_pc : pc_q;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = redir_st;
        end else begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // Without an ack the old read is still in flight and must drain first.
          if (mem_ack) begin
            req_addr_d = redirect_pc;
            state_d    = redir_st;
          end else begin
            state_d = SQUASH;
          end
        end else if (mem_ack) begin
          buf_d     = mem_rdata;
          inst_pc_d = req_addr_q;
          pc_d      = req_addr_q + XLEN'(INSN_BYTES);
          state_d   = HOLD;
        end
      end
      SQUASH: begin
        if (redirect) pc_d = redirect_pc;
        if (mem_ack) begin
          req_addr_d = squash_tgt;
          state_d    = misaligned(squash_tgt) ? FAULT : FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = redir_st;
        end else if (dec_ready) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      FAULT: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = redir_st;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs straight off the state and data registers.
  assign mem_req     = (state_q == FETCH) || (state_q == SQUASH);
  assign mem_addr    = req_addr_q;
  assign inst_valid  = (state_q == HOLD);
  assign fetch_fault = (state_q == FAULT);
  assign opcode      = buf_q[6:0];
  assign instruction = buf_q[31:7];
  assign inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a wrap-around instance, and a
// randomized run against a flag-based transaction model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        nRst, mem_ack, redirect, dec_ready;
  logic [31:0] mem_rdata, redirect_pc;
  logic        mem_req, inst_valid, fetch_fault;
  logic [31:0] mem_addr, inst_pc;
  logic [6:0]  opcode;
  logic [24:0] instruction;

  logic        w_nRst, w_ack, w_redirect, w_ready;
  logic [31:0] w_rdata, w_rpc;
  logic        w_req, w_valid, w_fault;
  logic [31:0] w_addr, w_ipc;
  logic [6:0]  w_op;
  logic [24:0] w_insn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .nRst(nRst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .dec_ready(dec_ready), .inst_valid(inst_valid),
    .opcode(opcode), .instruction(instruction), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .nRst(w_nRst), .mem_req(w_req), .mem_addr(w_addr),
    .mem_ack(w_ack), .mem_rdata(w_rdata), .redirect(w_redirect),
    .redirect_pc(w_rpc), .dec_ready(w_ready), .inst_valid(w_valid),
    .opcode(w_op), .instruction(w_insn), .inst_pc(w_ipc),
    .fetch_fault(w_fault)
  );

  typedef struct {
    logic        nrst, ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_word, e_ipc;
    logic        e_flt;
  } vec_t;

  function automatic vec_t mk(input logic nrst, input logic ack, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] rpc, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr, input logic e_val,
                              input logic [31:0] e_word, input logic [31:0] e_ipc,
                              input logic e_flt);
    vec_t v;
    v.nrst = nrst; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_word = e_word;
    v.e_ipc = e_ipc; v.e_flt = e_flt;
    return v;
  endfunction

  // Address is only meaningful with a request up, data only with valid; reset checks all.
  task automatic chk(input string nm, input logic rq, input logic [31:0] ad, input logic vl,
                     input logic [31:0] wd, input logic [31:0] ip, input logic fl,
                     input logic all);
    logic ok;
    ok = (mem_req == rq) && (inst_valid == vl) && (fetch_fault == fl);
    if (rq || all) ok = ok && (mem_addr == ad);
    if (vl || all) ok = ok && ({instruction, opcode} == wd) && (inst_pc == ip);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got req=%b addr=%h val=%b word=%h ipc=%h flt=%b want req=%b addr=%h val=%b word=%h ipc=%h flt=%b",
               nm, mem_req, mem_addr, inst_valid, {instruction, opcode}, inst_pc, fetch_fault,
               rq, ad, vl, wd, ip, fl);
    end
  endtask

  // Transaction-level model: is a read in flight (and will it be thrown away),
  // is a word waiting for the decoder, or are we parked on a bad target.
  logic        m_start, m_req, m_drop, m_valid, m_fault;
  logic [31:0] m_pc, m_addr, m_word, m_ipc;

  task automatic m_reset();
    m_start = 1; m_req = 0; m_drop = 0; m_valid = 0; m_fault = 0;
    m_pc = 32'h0; m_addr = 0; m_word = 0; m_ipc = 0;
  endtask

  task automatic m_goto(input logic [31:0] t);
    m_addr = t; m_drop = 0;
    if (t[1:0] != 2'b00) begin m_fault = 1; m_req = 0; end
    else begin m_fault = 0; m_req = 1; end
  endtask

  task automatic m_step(input logic nrst, input logic ack, input logic [31:0] rdata,
                        input logic redir, input logic [31:0] rpc, input logic rdy);
    if (!nrst) begin m_reset(); return; end
    if (m_start) begin
      m_start = 0;
      if (redir) m_pc = rpc;
      m_goto(m_pc);
    end else if (m_fault) begin
      if (redir) begin m_pc = rpc; m_goto(rpc); end
    end else if (m_req) begin
      if (ack) begin
        if (redir) begin m_pc = rpc; m_goto(rpc); end
        else if (m_drop) m_goto(m_pc);
        else begin
          m_word = rdata; m_ipc = m_addr; m_pc = m_addr + 32'd4;
          m_req = 0; m_valid = 1;
        end
      end else if (redir) begin
        m_pc = rpc; m_drop = 1;
      end
    end else if (m_valid) begin
      if (redir) begin m_valid = 0; m_pc = rpc; m_goto(rpc); end
      else if (rdy) begin m_valid = 0; m_goto(m_pc); end
    end
  endtask

  vec_t tbl[30];

  initial begin
    nRst = 0; mem_ack = 0; mem_rdata = 0; redirect = 0; redirect_pc = 0; dec_ready = 0;
    w_nRst = 0; w_ack = 0; w_rdata = 0; w_redirect = 0; w_rpc = 0; w_ready = 0;

    //                nrst ack rdata          red rpc            rdy  req addr         val word           ipc            flt
    tbl[0]  = mk(0, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0,        0, 32'h0,          32'h0,         0);
    tbl[1]  = mk(1, 0, 32'h0,          0, 32'h0,        1,   1, 32'h0,        0, 32'h0,          32'h0,         0);
    tbl[2]  = mk(1, 1, 32'h0050_0093,  0, 32'h0,        0,   0, 32'h0,        1, 32'h0050_0093,  32'h0,         0);
    tbl[3]  = mk(1, 0, 32'h0,          0, 32'h0,        1,   1, 32'h4,        0, 32'h0,          32'h0,         0);
    tbl[4]  = mk(1, 1, 32'h0000_006F,  0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_006F,  32'h4,         0);
    tbl[5]  = mk(1, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_006F,  32'h4,         0);
    tbl[6]  = mk(1, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_006F,  32'h4,         0);
    tbl[7]  = mk(1, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_006F,  32'h4,         0);
    tbl[8]  = mk(1, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_006F,  32'h4,         0);
    tbl[9]  = mk(1, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_006F,  32'h4,         0);
    tbl[10] = mk(1, 0, 32'h0,          0, 32'h0,        1,   1, 32'h8,        0, 32'h0,          32'h0,         0);
    tbl[11] = mk(1, 0, 32'h0,          1, 32'h100,      0,   1, 32'h8,        0, 32'h0,          32'h0,         0);
    tbl[12] = mk(1, 0, 32'h0,          0, 32'h0,        0,   1, 32'h8,        0, 32'h0,          32'h0,         0);
    tbl[13] = mk(1, 0, 32'h0,          0, 32'h0,        0,   1, 32'h8,        0, 32'h0,          32'h0,         0);
    tbl[14] = mk(1, 1, 32'hDEAD_BEEF,  0, 32'h0,        0,   1, 32'h100,      0, 32'h0,          32'h0,         0);
    tbl[15] = mk(1, 1, 32'h0000_0013,  0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_0013,  32'h100,       0);
    tbl[16] = mk(1, 0, 32'h0,          1, 32'h200,      1,   1, 32'h200,      0, 32'h0,          32'h0,         0);
    tbl[17] = mk(1, 1, 32'h0000_0037,  0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_0037,  32'h200,       0);
    tbl[18] = mk(1, 0, 32'h0,          1, 32'h102,      0,   0, 32'h0,        0, 32'h0,          32'h0,         1);
    tbl[19] = mk(1, 1, 32'h0,          0, 32'h0,        1,   0, 32'h0,        0, 32'h0,          32'h0,         1);
    tbl[20] = mk(1, 0, 32'h0,          1, 32'h104,      0,   1, 32'h104,      0, 32'h0,          32'h0,         0);
    tbl[21] = mk(1, 1, 32'h0000_0063,  0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_0063,  32'h104,       0);
    tbl[22] = mk(1, 0, 32'h0,          0, 32'h0,        1,   1, 32'h108,      0, 32'h0,          32'h0,         0);
    tbl[23] = mk(1, 0, 32'h0,          1, 32'h300,      0,   1, 32'h108,      0, 32'h0,          32'h0,         0);
    tbl[24] = mk(0, 0, 32'h0,          0, 32'h0,        0,   0, 32'h0,        0, 32'h0,          32'h0,         0);
    tbl[25] = mk(1, 0, 32'h0,          0, 32'h0,        0,   1, 32'h0,        0, 32'h0,          32'h0,         0);
    tbl[26] = mk(1, 1, 32'h0000_0003,  0, 32'h0,        0,   0, 32'h0,        1, 32'h0000_0003,  32'h0,         0);
    tbl[27] = mk(1, 0, 32'h0,          0, 32'h0,        1,   1, 32'h4,        0, 32'h0,          32'h0,         0);
    tbl[28] = mk(1, 0, 32'h0,          1, 32'h2,        0,   1, 32'h4,        0, 32'h0,          32'h0,         0);
    tbl[29] = mk(1, 1, 32'h0,          0, 32'h0,        0,   0, 32'h0,        0, 32'h0,          32'h0,         1);

    for (int i = 0; i < 30; i++) begin
      nRst = tbl[i].nrst; mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc; dec_ready = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val,
          tbl[i].e_word, tbl[i].e_ipc, tbl[i].e_flt, !tbl[i].nrst);
    end

    // PC wrap past the top of the address space.
    @(posedge clk); #1;
    w_nRst = 1;
    @(posedge clk); #1;
    total++;
    if (!(w_req && w_addr == 32'hFFFF_FFFC)) begin
      bad++; $display("FAIL wrap_first: got req=%b addr=%h want req=1 addr=fffffffc", w_req, w_addr);
    end
    w_ack = 1; w_rdata = 32'h0000_0013;
    @(posedge clk); #1;
    w_ack = 0;
    total++;
    if (!(w_valid && w_ipc == 32'hFFFF_FFFC && w_op == 7'h13)) begin
      bad++; $display("FAIL wrap_hold: got val=%b ipc=%h op=%h want val=1 ipc=fffffffc op=13", w_valid, w_ipc, w_op);
    end
    w_ready = 1;
    @(posedge clk); #1;
    w_ready = 0;
    total++;
    if (!(w_req && w_addr == 32'h0)) begin
      bad++; $display("FAIL wrap_second: got req=%b addr=%h want req=1 addr=00000000", w_req, w_addr);
    end

    // Randomized run against the model.
    nRst = 0; mem_ack = 0; redirect = 0; dec_ready = 0;
    @(posedge clk); #1;
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      nRst        = ($urandom_range(0, 199) != 0);
      mem_ack     = ($urandom_range(0, 2) != 0);
      mem_rdata   = $urandom;
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = {$urandom_range(0, 32'hFFFF) , 16'h0} | {16'h0, 14'($urandom), 2'b00};
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      dec_ready   = ($urandom_range(0, 1) != 0);
      @(posedge clk);
      m_step(nRst, mem_ack, mem_rdata, redirect, redirect_pc, dec_ready);
      #1;
      chk($sformatf("rand%0d", c), m_req, m_addr, m_valid, m_word, m_ipc, m_fault, !nRst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
